// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Write-side initiator for the register file's single write port. Results
// from the in-order main pipeline (no backpressure, always wins the port)
// are merged with results from a long-latency unit (divider / load miss)
// that wait in a small FIFO. At most one registered write leaves per cycle.
//
// A long-latency result is always older than any concurrent or later
// main-pipeline result. A main write to register A therefore squashes every
// buffered entry to A, including one being pushed on the same edge. Squashed
// entries still occupy a slot until they reach the head. They are then
// dropped without issuing a write.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low (0 = reset)
//   wreg_i       main pipeline write request
//   wd_i         main pipeline destination register
//   wdata_i      main pipeline result
//   lu_valid_i   long-latency result valid
//   lu_ready_o   FIFO can accept a push this cycle
//   lu_wd_i      long-latency destination register
//   lu_wdata_i   long-latency result
//   we_o         register file write enable   (registered)
//   waddr_o      register file write address  (registered)
//   wdata_o      register file write data     (registered)
//   pending_o    bit i set = a live buffered write to register i exists
//   count_o      current FIFO occupancy
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wreg_i,
    input  logic [ADDR_W-1:0]         wd_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      lu_valid_i,
    output logic                      lu_ready_o,
    input  logic [ADDR_W-1:0]         lu_wd_i,
    input  logic [DATA_W-1:0]         lu_wdata_i,
    output logic                      we_o,
    output logic [ADDR_W-1:0]         waddr_o,
    output logic [DATA_W-1:0]         wdata_o,
    output logic [(2**ADDR_W)-1:0]    pending_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage. Payload needs no reset; only the valid/squash bits do.
    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;
    logic [DEPTH-1:0]  ent_sq_q,  ent_sq_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic              we_q,    we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic main_hit;
    logic push;
    logic pop;
    logic head_live;
    logic push_sq;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    // A write to r0 is not a real write: it neither issues nor blocks a pop.
    assign main_hit = wreg_i && (wd_i != '0);

    // Ready looks only at the current occupancy. When full, a same-cycle pop
    // does not open a slot for the push.
    assign lu_ready_o = rst && (count_q < CNT_W'(DEPTH));

    assign push = lu_valid_i && lu_ready_o;
    assign pop  = !main_hit && (count_q != '0);

    assign head_live = ent_vld_q[rd_ptr_q] && !ent_sq_q[rd_ptr_q];

    // An incoming entry is dead on arrival if it targets r0 or collides with
    // the main write on the same edge, since the main result is younger.
    assign push_sq = (lu_wd_i == '0) || (main_hit && (lu_wd_i == wd_i));

    // -----------------------------------------------------------------------
    // Entry state next-state
    // -----------------------------------------------------------------------
    // Push and pop never address the same slot. Equal pointers mean the FIFO
    // is either empty (no pop) or full (no push).
    always_comb begin
        ent_vld_d = ent_vld_q;
        ent_sq_d  = ent_sq_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (main_hit && ent_vld_q[i] && (ent_addr_q[i] == wd_i)) begin
                ent_sq_d[i] = 1'b1;
            end
        end

        if (pop) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
        end

        if (push) begin
            ent_vld_d[wr_ptr_q] = 1'b1;
            ent_sq_d[wr_ptr_q]  = push_sq;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers and occupancy
    // -----------------------------------------------------------------------
    // DEPTH is a power of two, so the pointer wraps by natural overflow.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write port selection
    // -----------------------------------------------------------------------
    // The main pipeline always wins. A live head entry writes when the main
    // pipeline is silent. Popping a squashed head, or an idle cycle, issues no
    // write, and the address/data hold their previous values.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (main_hit) begin
            we_d    = 1'b1;
            waddr_d = wd_i;
            wdata_d = wdata_i;
        end else if (pop && head_live) begin
            we_d    = 1'b1;
            waddr_d = ent_addr_q[rd_ptr_q];
            wdata_d = ent_data_q[rd_ptr_q];
        end
    end

    // -----------------------------------------------------------------------
    // Control state registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld_q <= '0;
            ent_sq_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            ent_sq_q  <= ent_sq_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO payload storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= lu_wd_i;
            ent_data_q[wr_ptr_q] <= lu_wdata_i;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    // Only live entries mark their destination. r0 entries are always
    // squashed on entry. Bit 0 is also cleared explicitly so that ID never
    // stalls on r0.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && !ent_sq_q[i]) begin
                pending_o[ent_addr_q[i]] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter with default parameters (ADDR_W=5, DATA_W=32,
// DEPTH=4). A table of per-cycle vectors holds the inputs applied before a
// rising edge and the outputs expected just after it. A hand-written
// sequence follows for asynchronous reset in the middle of a drain.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wreg_i;
    logic [4:0]  wd_i;
    logic [31:0] wdata_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_wd_i;
    logic [31:0] lu_wdata_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic [31:0] pending_o;
    logic [2:0]  count_o;

    int n_assert = 0;
    int n_fail   = 0;

    wb_arbiter #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wreg_i     (wreg_i),
        .wd_i       (wd_i),
        .wdata_i    (wdata_i),
        .lu_valid_i (lu_valid_i),
        .lu_ready_o (lu_ready_o),
        .lu_wd_i    (lu_wd_i),
        .lu_wdata_i (lu_wdata_i),
        .we_o       (we_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .pending_o  (pending_o),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        luv;
        logic [4:0]  luwd;
        logic [31:0] ludata;
        logic        we;
        logic        chk_ad;   // compare waddr/wdata as well
        logic [4:0]  waddr;
        logic [31:0] wdo;
        logic [2:0]  cnt;
        logic [31:0] pend;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wreg, input int wd, input int wdata,
                                input logic luv, input int luwd, input int ludata,
                                input logic we, input logic ck, input int waddr,
                                input int wdo, input int cnt, input int pend,
                                input logic rdy);
        vec_t v;
        v.wreg   = wreg;
        v.wd     = 5'(wd);
        v.wdata  = 32'(wdata);
        v.luv    = luv;
        v.luwd   = 5'(luwd);
        v.ludata = 32'(ludata);
        v.we     = we;
        v.chk_ad = ck;
        v.waddr  = 5'(waddr);
        v.wdo    = 32'(wdo);
        v.cnt    = 3'(cnt);
        v.pend   = 32'(pend);
        v.rdy    = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        wreg_i     = 1'b0;
        wd_i       = '0;
        wdata_i    = '0;
        lu_valid_i = 1'b0;
        lu_wd_i    = '0;
        lu_wdata_i = '0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("reset we",      32'(we_o),       32'd0);
        chk("reset waddr",   32'(waddr_o),    32'd0);
        chk("reset wdata",   wdata_o,         32'd0);
        chk("reset count",   32'(count_o),    32'd0);
        chk("reset pending", pending_o,       32'd0);
        chk("reset ready",   32'(lu_ready_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("ready after release", 32'(lu_ready_o), 32'd1);

        //            wreg wd  wdata    luv luwd ludata  we ck waddr wdo     cnt pend        rdy
        // main writes, then idle hold
        vecs.push_back(mk(1, 3,  'h11,   0, 0,  0,      1, 1, 3,  'h11,   0, 0,          1));
        vecs.push_back(mk(1, 4,  'h22,   0, 0,  0,      1, 1, 4,  'h22,   0, 0,          1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      0, 1, 4,  'h22,   0, 0,          1));
        // fill with r5..r8 under a busy main pipeline, then drain in order
        vecs.push_back(mk(1, 1,  'h1001, 1, 5,  'h505,  1, 1, 1,  'h1001, 1, 'h20,       1));
        vecs.push_back(mk(1, 2,  'h1002, 1, 6,  'h606,  1, 1, 2,  'h1002, 2, 'h60,       1));
        vecs.push_back(mk(1, 10, 'h100A, 1, 7,  'h707,  1, 1, 10, 'h100A, 3, 'hE0,       1));
        vecs.push_back(mk(1, 11, 'h100B, 1, 8,  'h808,  1, 1, 11, 'h100B, 4, 'h1E0,      0));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 5,  'h505,  3, 'h1C0,      1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 6,  'h606,  2, 'h180,      1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 7,  'h707,  1, 'h100,      1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 8,  'h808,  0, 0,          1));
        // r9 buffered, then overtaken by a main write to r9
        vecs.push_back(mk(0, 0,  0,      1, 9,  'hAAAA, 0, 1, 8,  'h808,  1, 'h200,      1));
        vecs.push_back(mk(1, 9,  'hBBBB, 0, 0,  0,      1, 1, 9,  'hBBBB, 1, 0,          1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      0, 1, 9,  'hBBBB, 0, 0,          1));
        // push to r7 on the same edge as a main write to r7
        vecs.push_back(mk(1, 7,  'h7777, 1, 7,  'hDEAD, 1, 1, 7,  'h7777, 1, 0,          1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      0, 1, 7,  'h7777, 0, 0,          1));
        // r0 push is dead; wreg to r0 neither writes nor blocks a pop
        vecs.push_back(mk(1, 0,  'h55,   1, 0,  'h1234, 0, 1, 7,  'h7777, 1, 0,          1));
        vecs.push_back(mk(1, 0,  'h66,   1, 12, 'hC0C,  0, 1, 7,  'h7777, 1, 'h1000,     1));
        vecs.push_back(mk(1, 0,  'h999,  0, 0,  0,      1, 1, 12, 'hC0C,  0, 0,          1));
        // two entries to r13 drain in FIFO order
        vecs.push_back(mk(1, 1,  'h2,    1, 13, 'h1,    1, 1, 1,  'h2,    1, 'h2000,     1));
        vecs.push_back(mk(1, 2,  'h4,    1, 13, 'h3,    1, 1, 2,  'h4,    2, 'h2000,     1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 13, 'h1,    1, 'h2000,     1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 13, 'h3,    0, 0,          1));
        // full FIFO, pop with lu_valid held: no push until the next cycle
        vecs.push_back(mk(1, 1,  'h10,   1, 20, 'h20,   1, 1, 1,  'h10,   1, 'h00100000, 1));
        vecs.push_back(mk(1, 1,  'h11,   1, 21, 'h21,   1, 1, 1,  'h11,   2, 'h00300000, 1));
        vecs.push_back(mk(1, 1,  'h12,   1, 22, 'h22,   1, 1, 1,  'h12,   3, 'h00700000, 1));
        vecs.push_back(mk(1, 1,  'h13,   1, 23, 'h23,   1, 1, 1,  'h13,   4, 'h00F00000, 0));
        vecs.push_back(mk(0, 0,  0,      1, 24, 'h24,   1, 1, 20, 'h20,   3, 'h00E00000, 1));
        vecs.push_back(mk(1, 2,  'h55,   1, 24, 'h24,   1, 1, 2,  'h55,   4, 'h01E00000, 0));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 21, 'h21,   3, 'h01C00000, 1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 22, 'h22,   2, 'h01800000, 1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 23, 'h23,   1, 'h01000000, 1));
        vecs.push_back(mk(0, 0,  0,      0, 0,  0,      1, 1, 24, 'h24,   0, 0,          1));

        foreach (vecs[i]) begin
            wreg_i     = vecs[i].wreg;
            wd_i       = vecs[i].wd;
            wdata_i    = vecs[i].wdata;
            lu_valid_i = vecs[i].luv;
            lu_wd_i    = vecs[i].luwd;
            lu_wdata_i = vecs[i].ludata;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d we", i),      32'(we_o),       32'(vecs[i].we));
            chk($sformatf("v%0d count", i),   32'(count_o),    32'(vecs[i].cnt));
            chk($sformatf("v%0d pending", i), pending_o,       vecs[i].pend);
            chk($sformatf("v%0d ready", i),   32'(lu_ready_o), 32'(vecs[i].rdy));
            if (vecs[i].chk_ad) begin
                chk($sformatf("v%0d waddr", i), 32'(waddr_o), 32'(vecs[i].waddr));
                chk($sformatf("v%0d wdata", i), wdata_o,      vecs[i].wdo);
            end
            if (we_o === 1'b1) begin
                chk($sformatf("v%0d r0 never written", i), 32'(waddr_o != 5'd0), 32'd1);
            end
        end

        // Asynchronous reset with three entries buffered behind a busy main pipe
        for (int k = 0; k < 3; k++) begin
            wreg_i     = 1'b1;
            wd_i       = 5'(3 + k);
            wdata_i    = 32'(32'h300 + k);
            lu_valid_i = 1'b1;
            lu_wd_i    = 5'(25 + k);
            lu_wdata_i = 32'(32'h250 + k);
            @(posedge clk);
            #1;
        end
        lu_valid_i = 1'b0;
        chk("pre-reset count", 32'(count_o), 32'd3);
        chk("pre-reset we",    32'(we_o),    32'd1);
        #3 rst = 1'b0;
        #1;
        chk("async reset we",      32'(we_o),       32'd0);
        chk("async reset waddr",   32'(waddr_o),    32'd0);
        chk("async reset wdata",   wdata_o,         32'd0);
        chk("async reset count",   32'(count_o),    32'd0);
        chk("async reset pending", pending_o,       32'd0);
        chk("async reset ready",   32'(lu_ready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("held reset we",    32'(we_o),    32'd0);
        chk("held reset count", 32'(count_o), 32'd0);
        drive_idle();
        #3 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-reset c%0d we", k),      32'(we_o),       32'd0);
            chk($sformatf("post-reset c%0d count", k),   32'(count_o),    32'd0);
            chk($sformatf("post-reset c%0d pending", k), pending_o,       32'd0);
            chk($sformatf("post-reset c%0d ready", k),   32'(lu_ready_o), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
